multi_operand_sum_using_fifos: RTL
==================================

MULTI_OPERAND_SUM_USING_FIFOS -- requirements
Module: multi_operand_sum_using_fifos

Interface
REQ-001 Parameter width, default 8: data width of each input channel.
REQ-002 Parameter depth, default 10: entries per channel FIFO, minimum 2.
REQ-003 Parameter n_ch, default 2: number of operand channels, range 2..16.
REQ-004 Parameter out_width, default width + $clog2(n_ch): width of sum_data, minimum width.
REQ-005 Parameter saturate, default 0: 0 means wrap modulo 2^out_width; 1 means clamp to 2^out_width-1.
REQ-006 clk  input  1: single clock, rising edge.
REQ-007 rst  input  1: reset, asynchronous, active-high.
REQ-008 in_valid  input  n_ch: per-channel valid, bit i for channel i.
REQ-009 in_ready  output  n_ch: per-channel ready.
REQ-010 in_data  input  n_ch*width: channel i occupies bits [i*width +: width], unsigned.
REQ-011 sum_valid  output  1: sum available.
REQ-012 sum_ready  input  1: downstream accepts sum.
REQ-013 sum_data  output  out_width: sum of one operand from every channel.

Function
REQ-014 Channel i SHALL accept a word when in_valid[i] & in_ready[i], independently of the other channels.
REQ-015 in_ready[i] SHALL equal !full of channel i FIFO; a word is not accepted in the cycle a full FIFO pops.
REQ-016 All channel FIFOs SHALL pop together, only when every FIFO is non-empty and the output buffer is ready (join); no channel ever pops alone.
REQ-017 The join SHALL NOT depend on in_valid; operand pairing is strictly by FIFO order per channel.
REQ-018 The full sum SHALL be computed at width + $clog2(n_ch) bits, then reduced to out_width by wrap or clamp per saturate; no reduction when out_width >= full width.
REQ-019 The output stage SHALL be a 2-entry buffer with registered up_ready (high while at least one slot is free) and registered sum_valid/sum_data.
REQ-020 Latency: operands accepted on all channels in cycle 0 with everything empty SHALL give sum_valid in cycle 2.
REQ-021 Throughput: with sum_ready held high and all in_valid high, one sum per cycle SHALL be sustained.
REQ-022 sum_data SHALL remain stable while sum_valid & !sum_ready.
REQ-023 Sums SHALL leave in the order the operand sets were joined; no drops, no duplicates.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its count unchanged; the FIFO pointers SHALL wrap at depth-1 to 0.

Reset
REQ-025 While rst is high, all FIFOs SHALL be empty, the output buffer empty, sum_valid=0, sum_data=0, and in_ready all ones.
REQ-026 Reset asserted mid-operation SHALL discard all buffered operands and sums immediately; the first sum after reset SHALL use only post-reset operands.

Structure
REQ-027 Channel FIFOs SHALL reuse flip_flop_fifo_with_counter, one per channel, instantiated in a generate loop.
REQ-028 The output stage SHALL be one new sub-module, sum_double_buffer, parametrised by out_width.
REQ-029 A shared package SHALL hold the full-width function (width + $clog2(n_ch)) and the wrap/clamp reduction function.

Verification
REQ-030 Reset check: n_ch=3, width=8, depth=4; assert rst -> sum_valid=0, in_ready=3'b111.
REQ-031 Latency check: same config; channels present 10, 20, 30 in cycle 0 -> sum_valid=1 in cycle 2 with sum_data=60.
REQ-032 Skew check: ch0=1 and ch1=2 in cycle 0, ch2=3 in cycle 5 -> no sum before cycle 7, sum_data=6 in cycle 7.
REQ-033 Backpressure check: sum_ready=0 and all in_valid held high -> exactly 6 operand sets accepted (4 in FIFOs, 2 in buffer), then in_ready=3'b000; then release sum_ready -> 6 sums in order at 1 per cycle.
REQ-034 Arithmetic check: out_width=8, operands 200, 100, 50 -> sum_data=94 with saturate=0, 255 with saturate=1; default out_width=10 -> 350.
REQ-035 Reset mid-operation check: 3 sets buffered, assert rst for 1 cycle, then present 1, 1, 1 -> only sum_data=3 emerges.

Source files
------------

// File: rtl/multi_operand_sum_using_fifos_pkg.sv
// Shared types and arithmetic helpers for the multi-operand FIFO adder.
package multi_operand_sum_using_fifos_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  localparam int SUM_MAX_W = 64;

  // Width that holds the sum of n unsigned w-bit operands without loss.
  function automatic int full_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  // Reduce a lossless sum to out_w bits by wrapping or clamping.
  // Values that already fit pass through untouched.
  function automatic logic [SUM_MAX_W-1:0] reduce_sum(input logic [SUM_MAX_W-1:0] s,
                                                      input int out_w,
                                                      input bit sat);
    logic [SUM_MAX_W-1:0] lim;
    if (out_w >= SUM_MAX_W) return s;
    lim = (64'd1 << out_w) - 64'd1;
    if (s > lim) return sat ? lim : (s & lim);
    return s;
  endfunction

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Flop-based FIFO with an occupancy counter; dout shows the head entry combinationally.
module flip_flop_fifo_with_counter #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(depth));
  assign empty   = (count_q == '0);
  // A full FIFO refuses a push even in the cycle it pops.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sum_double_buffer.sv
// Two-entry output buffer: registered up_ready, down_valid and down_data.
module sum_double_buffer
  import multi_operand_sum_using_fifos_pkg::*;
#(
  parameter int out_width = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [out_width-1:0] up_data,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [out_width-1:0] down_data
);

  buf_state_e           state_q, state_d;
  logic [out_width-1:0] data_q, data_d;
  logic [out_width-1:0] skid_q, skid_d;
  logic                 valid_q, valid_d;
  logic                 up_ready_q, up_ready_d;
  logic                 push, pop;

  assign push       = up_valid & up_ready_q;
  assign pop        = valid_q & down_ready;
  assign up_ready   = up_ready_q;
  assign down_valid = valid_q;
  assign down_data  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          data_d  = up_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          data_d = up_data;
        end else if (push) begin
          skid_d  = up_data;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // up_ready is low here, so only the drain can happen.
        if (pop) begin
          data_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    valid_d    = (state_d != BUF_EMPTY);
    up_ready_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      data_q     <= '0;
      skid_q     <= '0;
      valid_q    <= 1'b0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      skid_q     <= skid_d;
      valid_q    <= valid_d;
      up_ready_q <= up_ready_d;
    end
  end

endmodule

// File: rtl/multi_operand_sum_using_fifos.sv
// Per-channel operand FIFOs joined into one adder, feeding a two-entry output buffer.
module multi_operand_sum_using_fifos
  import multi_operand_sum_using_fifos_pkg::*;
#(
  parameter int width     = 8,
  parameter int depth     = 10,
  parameter int n_ch      = 2,
  parameter int out_width = width + $clog2(n_ch),
  parameter int saturate  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [n_ch-1:0]         in_valid,
  output logic [n_ch-1:0]         in_ready,
  input  logic [n_ch*width-1:0]   in_data,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [out_width-1:0]    sum_data
);

  localparam int FULL_W = full_width(width, n_ch);

  logic [width-1:0]     fifo_dout [n_ch];
  logic [n_ch-1:0]      fifo_full;
  logic [n_ch-1:0]      fifo_empty;
  logic                 all_avail;
  logic                 buf_up_ready;
  logic                 join_pop;
  logic [FULL_W-1:0]    full_sum;
  logic [out_width-1:0] sum_in;

  // The join looks only at FIFO occupancy, so pairing follows FIFO order.
  assign all_avail = &(~fifo_empty);
  assign join_pop  = all_avail & buf_up_ready;

  genvar gi;
  generate
    for (gi = 0; gi < n_ch; gi++) begin : g_ch
      flip_flop_fifo_with_counter #(
        .width (width),
        .depth (depth)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid[gi]),
        .din   (in_data[gi*width +: width]),
        .pop   (join_pop),
        .dout  (fifo_dout[gi]),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi])
      );
      assign in_ready[gi] = ~fifo_full[gi];
    end
  endgenerate

  always_comb begin
    full_sum = '0;
    for (int i = 0; i < n_ch; i++) begin
      full_sum = full_sum + FULL_W'(fifo_dout[i]);
    end
  end

  assign sum_in = out_width'(reduce_sum(64'(full_sum), out_width, saturate != 0));

  sum_double_buffer #(
    .out_width (out_width)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (all_avail),
    .up_ready   (buf_up_ready),
    .up_data    (sum_in),
    .down_valid (sum_valid),
    .down_ready (sum_ready),
    .down_data  (sum_data)
  );

endmodule
